// File: rtl/ahb_sram_slave_param_if.sv
// AHB-Lite bus bundle between the decoder/mux and the SRAM slave.
// The master modport is the bus side. The slave modport is the memory side.
interface ahb_sram_slave_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave_param.sv
// Parametrised AHB-Lite SRAM slave.
// It supports configurable data width, depth and wait states, byte-lane write masking,
// and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_BYTES   = 8192,
  parameter int WAIT_STATES = 0
) (
  input logic HCLK,
  input logic HRESET,
  ahb_sram_slave_param_if.slave bus
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int OFF_W  = $clog2(MEM_BYTES);
  localparam int DEPTH  = MEM_BYTES / NB;
  localparam int IDX_W  = OFF_W - LANE_W;
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  // A legal accept goes through the wait states only when some are configured.
  localparam state_t OK_NEXT = (WAIT_STATES > 0) ? S_WAIT : S_DATA;

  state_t state, state_nxt;
  logic [2:0]       wait_cnt;
  logic [OFF_W-1:0] addr_q;
  logic             write_q;
  logic [2:0]       size_q;

  logic                  accept;
  logic                  illegal;
  logic                  size_bad;
  logic                  misaligned;
  logic                  out_of_range;
  logic [7:0]            align_mask;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic [IDX_W-1:0]      idx;
  logic [NB-1:0]         byte_mask;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign idx = addr_q[OFF_W-1:LANE_W];

  // Address-phase accept and classification of the incoming transfer.
  always_comb begin
    accept       = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    size_bad     = (bus.HSIZE > 3'(LANE_W));
    align_mask   = (8'd1 << bus.HSIZE) - 8'd1;
    misaligned   = |(bus.HADDR[7:0] & align_mask);
    addr_hi      = bus.HADDR >> OFF_W;
    out_of_range = |addr_hi;
    illegal      = size_bad | misaligned | out_of_range;
  end

  // State register and wait counter.
  // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state != S_WAIT)
        wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != 3'd0)
        wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Capture the address-phase controls on every accept.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else if (accept) begin
      addr_q  <= bus.HADDR[OFF_W-1:0];
      write_q <= bus.HWRITE;
      size_q  <= bus.HSIZE;
    end
  end

  // Next-state logic. IDLE, DATA and ERR2 all accept a new transfer.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) state_nxt = illegal ? S_ERR1 : OK_NEXT;
        else        state_nxt = S_IDLE;
      end
      S_WAIT:  if (wait_cnt == 3'd0) state_nxt = S_DATA;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs decoded from the state. Read data is taken straight from the array.
  always_comb begin
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 2'b00;
    bus.HRDATA    = '0;
    unique case (state)
      S_WAIT: bus.HREADYOUT = 1'b0;
      S_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 2'b01;
      end
      S_ERR2: bus.HRESP = 2'b01;
      S_DATA: if (!write_q) bus.HRDATA = mem[idx];
      default: ;
    endcase
  end

  // Little-endian lane enables: 2^size bytes starting at the lane offset.
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < NB; b++)
      byte_mask[b] = (b >= int'(addr_q[LANE_W-1:0])) &&
                     (b <  int'(addr_q[LANE_W-1:0]) + (1 << size_q));
  end

  // Commit write data at the edge that ends the DATA cycle.
  // NOTE: the array has no reset. SRAM contents survive HRESET, and a reset would defeat RAM inference.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && write_q) begin
      for (int b = 0; b < NB; b++)
        if (byte_mask[b]) mem[idx][b*8 +: 8] <= bus.HWDATA[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave_param.sv
// Directed bench for ahb_sram_slave_param using three instances:
// 32-bit with no wait states, 32-bit with three wait states, and 64-bit with no wait states.
module tb_ahb_sram_slave_param;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  int vectors     = 0;
  int miscompares = 0;

  // Shared master-side drive; only the selected instance (act) sees HSEL.
  logic [2:0]  hsel;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  int          act;
  logic        hready;
  logic        cur_ready;
  logic [1:0]  cur_resp;
  logic [63:0] cur_rdata;

  ahb_sram_slave_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
  ahb_sram_slave_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();
  ahb_sram_slave_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  assign hready    = (act == 1) ? bus3.HREADYOUT : (act == 2) ? bus64.HREADYOUT : bus0.HREADYOUT;
  assign cur_ready = hready;
  assign cur_resp  = (act == 1) ? bus3.HRESP : (act == 2) ? bus64.HRESP : bus0.HRESP;
  assign cur_rdata = (act == 1) ? {32'd0, bus3.HRDATA} :
                     (act == 2) ? bus64.HRDATA : {32'd0, bus0.HRDATA};

  assign bus0.HSEL  = hsel[0];  assign bus3.HSEL  = hsel[1];  assign bus64.HSEL  = hsel[2];
  assign bus0.HADDR = haddr;    assign bus3.HADDR = haddr;    assign bus64.HADDR = haddr;
  assign bus0.HTRANS = htrans;  assign bus3.HTRANS = htrans;  assign bus64.HTRANS = htrans;
  assign bus0.HWRITE = hwrite;  assign bus3.HWRITE = hwrite;  assign bus64.HWRITE = hwrite;
  assign bus0.HSIZE = hsize;    assign bus3.HSIZE = hsize;    assign bus64.HSIZE = hsize;
  assign bus0.HWDATA = hwdata[31:0];
  assign bus3.HWDATA = hwdata[31:0];
  assign bus64.HWDATA = hwdata;
  assign bus0.HREADY = hready;  assign bus3.HREADY = hready;  assign bus64.HREADY = hready;

  ahb_sram_slave_param #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(8192), .WAIT_STATES(0))
    dut0 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus0));
  ahb_sram_slave_param #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(8192), .WAIT_STATES(3))
    dut3 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus3));
  ahb_sram_slave_param #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_BYTES(8192), .WAIT_STATES(0))
    dut64 (.HCLK(HCLK), .HRESET(HRESET), .bus(bus64));

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_idle();
    hsel   = 3'b000;
    htrans = 2'b00;
    haddr  = 32'd0;
    hwrite = 1'b0;
    hsize  = 3'd0;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz,
                            input logic [1:0] tr);
    hsel      = 3'b000;
    hsel[act] = 1'b1;
    haddr     = a;
    hwrite    = w;
    hsize     = sz;
    htrans    = tr;
  endtask

  // Walk one data phase until HREADYOUT is high, then step past the final edge.
  task automatic wait_ready(output int lows, output logic [63:0] rd,
                            output logic [1:0] rf, output logic [1:0] rl);
    logic done;
    lows = 0; rd = '0; rf = 2'b00; rl = 2'b00; done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge HCLK);
      if (i == 0) rf = cur_resp;
      if (cur_ready) begin
        rd = cur_rdata; rl = cur_resp; done = 1'b1;
      end else begin
        lows++;
      end
      tick();
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL data_phase_timeout: HREADYOUT still low after 16 cycles, required high");
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [63:0] wd, output logic [63:0] rd, output int lows,
                      output logic [1:0] rf, output logic [1:0] rl);
    drive_addr(a, w, sz, 2'b10);
    tick();
    drive_idle();
    hwdata = wd;
    wait_ready(lows, rd, rf, rl);
  endtask

  // Write expected to complete OKAY after exp_lows wait cycles with HRDATA held at zero.
  task automatic wr(input string name, input logic [31:0] a, input logic [2:0] sz,
                    input logic [63:0] wd, input int exp_lows);
    logic [63:0] rd; int lows; logic [1:0] rf, rl;
    xfer(a, 1'b1, sz, wd, rd, lows, rf, rl);
    vectors++;
    if (lows !== exp_lows || rf !== 2'b00 || rl !== 2'b00 || rd !== 64'd0) begin
      miscompares++;
      $display("FAIL %s: lows=%0d resp=%b/%b rdata=%h, required lows=%0d resp=00/00 rdata=0",
               name, lows, rf, rl, rd, exp_lows);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [2:0] sz,
                        input logic [63:0] exp, input int exp_lows);
    logic [63:0] rd; int lows; logic [1:0] rf, rl;
    xfer(a, 1'b0, sz, 64'd0, rd, lows, rf, rl);
    vectors++;
    if (rd !== exp || lows !== exp_lows || rf !== 2'b00 || rl !== 2'b00) begin
      miscompares++;
      $display("FAIL %s: rdata=%h lows=%0d resp=%b/%b, required rdata=%h lows=%0d resp=00/00",
               name, rd, lows, rf, rl, exp, exp_lows);
    end
  endtask

  task automatic err_chk(input string name, input logic [31:0] a, input logic [2:0] sz);
    logic [63:0] rd; int lows; logic [1:0] rf, rl;
    xfer(a, 1'b1, sz, 64'hFFFF_FFFF_FFFF_FFFF, rd, lows, rf, rl);
    vectors++;
    if (lows !== 1 || rf !== 2'b01 || rl !== 2'b01) begin
      miscompares++;
      $display("FAIL %s: lows=%0d resp=%b/%b, required lows=1 resp=01/01", name, lows, rf, rl);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; act = 0; hwdata = '0;
    drive_idle();
    repeat (3) tick();
    vectors++;
    if ({bus0.HREADYOUT, bus3.HREADYOUT, bus64.HREADYOUT} !== 3'b111 ||
        {bus0.HRESP, bus3.HRESP, bus64.HRESP} !== 6'd0 ||
        {bus0.HRDATA, bus3.HRDATA, bus64.HRDATA} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b resp=%b/%b/%b, required ready=111 resp=00 rdata=0",
               {bus0.HREADYOUT, bus3.HREADYOUT, bus64.HREADYOUT},
               bus0.HRESP, bus3.HRESP, bus64.HRESP);
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_word();
    act = 0;
    wr("word_write", 32'h10, 3'd2, 64'hDEAD_BEEF, 0);
    rd_chk("word_read", 32'h10, 3'd2, 64'hDEAD_BEEF, 0);
  endtask

  task automatic test_byte_mask();
    act = 0;
    wr("mask_word", 32'h20, 3'd2, 64'h1122_3344, 0);
    wr("mask_byte", 32'h21, 3'd0, 64'h0000_AA00, 0);
    wr("mask_half", 32'h22, 3'd1, 64'hBBCC_0000, 0);
    rd_chk("mask_read", 32'h20, 3'd2, 64'hBBCC_AA44, 0);
  endtask

  task automatic test_errors();
    act = 0;
    wr("err_prefill", 32'h0, 3'd2, 64'h7654_3210, 0);
    err_chk("err_misaligned", 32'h2, 3'd2);
    err_chk("err_out_of_range", 32'h2000, 3'd2);
    err_chk("err_size_too_big", 32'h0, 3'd3);
    rd_chk("err_mem_unchanged", 32'h0, 3'd2, 64'h7654_3210, 0);
    act = 1;
    err_chk("err_with_wait_states", 32'h1, 3'd1);
  endtask

  task automatic test_wait_states();
    logic [63:0] rda, rdb; int la, lb; logic [1:0] rf, rl;
    act = 1;
    wr("ws_write_a", 32'h40, 3'd2, 64'h1357_9BDF, 3);
    wr("ws_write_b", 32'h44, 3'd2, 64'h2468_ACE0, 3);
    rd_chk("ws_single_read", 32'h40, 3'd2, 64'h1357_9BDF, 3);
    // NONSEQ pair: the second address phase is held until the first data phase completes.
    drive_addr(32'h40, 1'b0, 3'd2, 2'b10);
    tick();
    drive_addr(32'h44, 1'b0, 3'd2, 2'b10);
    wait_ready(la, rda, rf, rl);
    drive_idle();
    vectors++;
    if (la !== 3 || rda !== 64'h1357_9BDF || rl !== 2'b00) begin
      miscompares++;
      $display("FAIL ws_pair_first: lows=%0d rdata=%h resp=%b, required lows=3 rdata=13579bdf resp=00",
               la, rda, rl);
    end
    wait_ready(lb, rdb, rf, rl);
    vectors++;
    if (lb !== 3 || rdb !== 64'h2468_ACE0 || rf !== 2'b00 || rl !== 2'b00) begin
      miscompares++;
      $display("FAIL ws_pair_second: lows=%0d rdata=%h resp=%b, required lows=3 rdata=2468ace0 resp=00",
               lb, rdb, rl);
    end
  endtask

  task automatic raw_pair(input string name, input logic [31:0] a, input logic [2:0] sz,
                          input logic [63:0] val);
    logic [63:0] rd; int lows; logic [1:0] rf, rl;
    drive_addr(a, 1'b1, sz, 2'b10);
    tick();
    drive_addr(a, 1'b0, sz, 2'b10);
    hwdata = val;
    wait_ready(lows, rd, rf, rl);
    drive_idle();
    vectors++;
    if (lows !== 0 || rd !== 64'd0 || rl !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_write_phase: lows=%0d rdata=%h resp=%b, required lows=0 rdata=0 resp=00",
               name, lows, rd, rl);
    end
    wait_ready(lows, rd, rf, rl);
    vectors++;
    if (lows !== 0 || rd !== val || rl !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_read_phase: lows=%0d rdata=%h resp=%b, required lows=0 rdata=%h resp=00",
               name, lows, rd, rl, val);
    end
  endtask

  task automatic test_back_to_back();
    act = 0;
    raw_pair("raw32", 32'h40, 3'd2, 64'h5A5A_5A5A);
    act = 2;
    raw_pair("raw64", 32'h48, 3'd3, 64'h0123_4567_89AB_CDEF);
  endtask

  task automatic test_idle_busy();
    logic [1:0] trs [2];
    trs[0] = 2'b00;
    trs[1] = 2'b01;
    act = 0;
    hwdata = 64'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        drive_addr(32'h10, 1'b1, 3'd2, trs[i]);
      end else begin
        drive_addr(32'h10, 1'b1, 3'd2, 2'b10);
        hsel = 3'b000;
      end
      tick();
      drive_idle();
      @(negedge HCLK);
      vectors++;
      if (cur_ready !== 1'b1 || cur_resp !== 2'b00 || cur_rdata !== 64'd0) begin
        miscompares++;
        $display("FAIL idle_case_%0d: ready=%b resp=%b rdata=%h, required ready=1 resp=00 rdata=0",
                 i, cur_ready, cur_resp, cur_rdata);
      end
      tick();
    end
    rd_chk("idle_mem_unchanged", 32'h10, 3'd2, 64'hDEAD_BEEF, 0);
  endtask

  task automatic test_reset_mid();
    // A read DATA cycle is cut short by reset; HRDATA must drop with no clock edge.
    act = 0;
    drive_addr(32'h10, 1'b0, 3'd2, 2'b10);
    tick();
    drive_idle();
    @(negedge HCLK);
    vectors++;
    if (cur_rdata !== 64'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rst_pre_read: rdata=%h, required deadbeef", cur_rdata);
    end
    #2 HRESET = 1'b1;
    #1;
    vectors++;
    if (cur_rdata !== 64'd0 || cur_ready !== 1'b1 || cur_resp !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_async_read: rdata=%h ready=%b resp=%b, required 0/1/00",
               cur_rdata, cur_ready, cur_resp);
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();
    // A write is caught in WAIT; it must never reach the array.
    act = 1;
    wr("rst_prefill", 32'h80, 3'd2, 64'h1111_1111, 3);
    drive_addr(32'h80, 1'b1, 3'd2, 2'b10);
    tick();
    drive_idle();
    hwdata = 64'hCAFE_F00D;
    @(negedge HCLK);
    vectors++;
    if (cur_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_in_wait: ready=%b, required 0", cur_ready);
    end
    #2 HRESET = 1'b1;
    #1;
    vectors++;
    if (cur_ready !== 1'b1 || cur_resp !== 2'b00 || cur_rdata !== 64'd0) begin
      miscompares++;
      $display("FAIL rst_async_wait: ready=%b resp=%b rdata=%h, required 1/00/0",
               cur_ready, cur_resp, cur_rdata);
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();
    rd_chk("rst_write_discarded", 32'h80, 3'd2, 64'h1111_1111, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_mask();
    test_errors();
    test_wait_states();
    test_back_to_back();
    test_idle_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave_param.md
Name: ahb_sram_slave_param

Overview:
Parametrised AHB-Lite SRAM slave that supersedes the fixed 32-bit, zero-wait SRAM slave. It adds:
- configurable data width, memory depth and wait states
- correct address-phase/data-phase pipelining
- byte-lane write masking for any legal HSIZE
- a two-cycle AHB ERROR response for illegal accesses

It sits behind the AHB decoder/mux as a memory slave.

Parameters:
DATA_WIDTH, 32, bus width in bits; legal values 32 or 64; NB = DATA_WIDTH/8 byte lanes.
ADDR_WIDTH, 32, HADDR width.
MEM_BYTES, 8192, memory size in bytes; power of two, multiple of NB; depth = MEM_BYTES/NB words.
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; range 0..7.

Ports:
HCLK  in  1  bus clock, all state on rising edge.
HRESET  in  1  asynchronous, active-high reset.
HSEL  in  1  slave select from decoder.
HADDR  in  ADDR_WIDTH  byte address; only offset HADDR[log2(MEM_BYTES)-1:0] is used for indexing.
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
HWRITE  in  1  1=write.
HSIZE  in  3  transfer size, 2^HSIZE bytes.
HWDATA  in  DATA_WIDTH  write data, valid in data phase.
HREADY  in  1  bus-level ready (mux output).
HRDATA  out  DATA_WIDTH  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  2  00=OKAY, 01=ERROR.

Behaviour:
- Reset (HRESET=1, async): HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0. Memory contents are not cleared.
- Address-phase accept: HSEL & HTRANS[1] & HREADY at a rising edge. On accept, latch HADDR, HWRITE and HSIZE, then classify the access.
- IDLE/BUSY transfers, or an unselected slave: no state change; the next data phase is zero-wait OKAY.
- Illegal access (any of):
  - HSIZE > log2(NB)
  - address not aligned to 2^HSIZE
  - offset >= MEM_BYTES, i.e. any HADDR bits above log2(MEM_BYTES)-1 are nonzero
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=00. On a legal accept, go to WAIT if WAIT_STATES>0, else DATA. On an illegal accept, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=00. Counter loads WAIT_STATES-1 and decrements each cycle; at 0, go to DATA.
  - DATA: HREADYOUT=1, HRESP=00; the final data-phase cycle. Leave on the next edge. A new accept at that edge follows the IDLE rules (back-to-back pipelining); otherwise return to IDLE.
  - ERR1: HREADYOUT=0, HRESP=01; go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. A new accept at this edge follows the IDLE rules; otherwise return to IDLE.
- Write:
  - HWDATA is sampled only at the edge ending DATA.
  - Byte mask = ((1<<2^HSIZE)-1) << (addr mod NB), little-endian lanes; only masked bytes of word (offset/NB) are updated.
  - No memory update in ERR1/ERR2 or WAIT.
- Read:
  - In DATA, HRDATA = the full word at the latched index, read combinationally from the array. All lanes are driven; the master selects lanes.
  - Outside a read DATA cycle, HRDATA = 0.
- Read-after-write: a write committing at the DATA edge is visible to a read whose DATA cycle is the next cycle. This is inherent because the array is read after the edge.
- Wait-state timing: address-phase edge to HREADYOUT=1 takes exactly WAIT_STATES+1 cycles for OKAY. ERROR always takes 2 cycles, independent of WAIT_STATES.
- HSEL or HTRANS changes during WAIT/ERR1 are ignored: HREADY is low, so there is no accept.
- Reset mid-transfer: outputs return to reset values immediately; a pending write is discarded.

Test Plan:
- Word write/read, DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF @0x10, then read @0x10. Required: HRDATA=0xDEADBEEF in the read data phase, HREADYOUT never low, HRESP=00.
- Byte/halfword masking: write word 0x11223344 @0x20, byte 0xAA @0x21 (HWDATA=0x0000AA00), halfword 0xBBCC @0x22 (HWDATA=0xBBCC0000). Required: read @0x20 returns 0xBBCCAA44.
- Wait states, WAIT_STATES=3: single read. Required: HREADYOUT low for exactly 3 cycles, then high for 1 cycle with valid data. A back-to-back NONSEQ pair shows 3 low cycles per transfer.
- Errors:
  - HSIZE=010 @0x2 (misaligned): HREADYOUT=0/HRESP=01, then HREADYOUT=1/HRESP=01, and memory is unchanged.
  - Access @MEM_BYTES (0x2000): same two-cycle ERROR.
  - HSIZE=011 with DATA_WIDTH=32: same two-cycle ERROR.
- Pipelined read-after-write: write 0x5A5A5A5A @0x40 immediately followed by a read @0x40 (read address phase overlaps the write data phase). Required: read returns 0x5A5A5A5A. Repeat with DATA_WIDTH=64, doubleword write/read @0x48, value 0x0123456789ABCDEF.
- Reset/idle: assert HRESET during a WAIT cycle. Required: HREADYOUT=1, HRESP=00 and HRDATA=0 asynchronously, and the pending write is absent on a later read. IDLE/BUSY transfers and HSEL=0 produce zero-wait OKAY with no memory change.
